uba_status_reg: RTL
===================

// Module: uba_status_reg
// PURPOSE
//   UBA Status Register (UBASR, IO addr 763100); consumer of the NXD timeout FSM.
//   - Latches error events: NXD (from setNXD), TMO, BMD, BPE, PWRLOW.
//   - Holds the PI level assignments and turns device BR requests into KS10 PI requests.
//   - Generates a stretched UBA init pulse to the Unibus devices.
//   - Sits between the UBA bus-cycle logic (read/write strobes) and the device/PI side.
// PARAMETERS
//   INIT_CYCLES  100  width of ubaINIT pulse in clk cycles (2..255)
// PORTS
//   clk       in   1     clock
//   rst       in   1     synchronous reset, active high
//   csrWRITE  in   1     one-cycle strobe: write busDATAI into UBASR
//   busDATAI  in   36    write data [0:35], DEC bit numbering
//   setNXD    in   1     non-existent device event (one-cycle)
//   setTMO    in   1     bus timeout event
//   setBMD    in   1     bad memory data event
//   setBPE    in   1     bus parity error event
//   setPWRLOW in   1     Unibus AC-LO event
//   devINTH   in   1     OR of device BR7/BR6 requests (level)
//   devINTL   in   1     OR of device BR5/BR4 requests (level)
//   regUBASR  out  36    register readback [0:35]
//   ubaINIT   out  1     device init pulse, INIT_CYCLES wide
//   ubaDXFR   out  1     disable DMA transfers (DXFR set and any error flag set)
//   piREQ     out  7     PI request [1:7], one bit per PI level
// BEHAVIOUR
//   - Field map [0:35]; unlisted bits read 0 and ignore writes:
//     18 TMO, 19 BMD, 20 BPE, 21 NXD, 24 INTH, 25 INTL, 26 PWRLOW,
//     28 DXFR, 29 INIT, 30:32 PIH, 33:35 PIL.
//   - Reset: all flags 0, PIH=PIL=0, ubaINIT=0, ubaDXFR=0, piREQ=0, init counter=0.
//   - Error flags (TMO, BMD, BPE, NXD, PWRLOW) are sticky and write-1-to-clear.
//     - A flag sets on the clk after its set* input is high.
//     - Set and W1C in the same cycle: set wins, so the flag stays 1.
//   - DXFR, PIH and PIL are plain read/write, loaded on csrWRITE.
//   - INTH and INTL are read-only: registered copies of devINTH/devINTL, 1-cycle latency.
//   - INIT reads 1 while ubaINIT is active.
//     - Writing 1 to bit 29 loads the counter with INIT_CYCLES; ubaINIT rises the next cycle.
//     - A write of 1 while the pulse is active restarts the counter.
//     - Writing 0 has no effect. The counter saturates at 0.
//   - A write with INIT=1 also clears every error flag and DXFR, and zeroes PIH and PIL.
//     This overrides the other data bits in that write.
//   - piREQ is registered.
//     - piREQ[n] = (INTH & PIH==n) | (INTL & PIL==n).
//     - Level 0 means disabled. PIH==PIL is legal; the two requests OR.
//   - ubaDXFR = DXFR & (TMO|BMD|BPE|NXD), registered.
//   - rst asserted mid-pulse drops ubaINIT on the next clk; rst itself does not pulse ubaINIT.
// CONFIGURATION
//   UBA_ERRINT_EN
//     - Defined: any error flag set also asserts piREQ[PIH] (when PIH!=0) until that flag is cleared.
//     - Undefined: error flags never request interrupts; only INTH/INTL do.
// STRUCTURE
//   - Shared header uba.vh holds:
//     - bit-position constants (UBASR_TMO, UBASR_NXD, UBASR_INIT, UBASR_PIH, UBASR_PIL ...);
//     - the UBASR write mask;
//     - the UBASR IO address.
//   - One sub-module, uba_init_timer: loadable down-counter producing ubaINIT.
//   - The flag, PI and DXFR logic stays in this module.
// TESTING
//   - Reset: rst 1 cycle -> regUBASR=0, piREQ=0, ubaINIT=0, ubaDXFR=0.
//   - NXD: setNXD pulse -> bit21=1 next clk.
//     - csrWRITE with bit21=1 -> bit21=0.
//     - setNXD and W1C in the same cycle -> bit21 stays 1.
//   - PI: write PIH=3, PIL=5.
//     - devINTH=1 -> piREQ=7'b0010000 ([3]) after 2 clk.
//     - Add devINTL=1 -> piREQ[3] and [5] both set.
//     - PIH=0 -> no high request.
//   - Init: INIT_CYCLES=100, write bit29=1 -> ubaINIT high exactly 100 cycles, bit29 reads 1 throughout.
//     - Rewrite at cycle 50 -> pulse lasts 150 total.
//     - rst at cycle 20 -> ubaINIT=0 next clk.
//   - DXFR: write DXFR=1 with no errors -> ubaDXFR=0.
//     - setTMO -> ubaDXFR=1 within 2 clk.
//     - W1C TMO -> ubaDXFR=0.
//   - UBA_ERRINT_EN: PIH=2, setBPE -> piREQ[2]=1 with the macro, 0 without it.

Source files
------------

// File: rtl/uba_status_reg_pkg.sv
// Shared UBASR definitions: bit positions in DEC [0:35] numbering, write mask, IO address.
package uba_status_reg_pkg;

  localparam int unsigned UBASR_TMO    = 18;
  localparam int unsigned UBASR_BMD    = 19;
  localparam int unsigned UBASR_BPE    = 20;
  localparam int unsigned UBASR_NXD    = 21;
  localparam int unsigned UBASR_INTH   = 24;
  localparam int unsigned UBASR_INTL   = 25;
  localparam int unsigned UBASR_PWRLOW = 26;
  localparam int unsigned UBASR_DXFR   = 28;
  localparam int unsigned UBASR_INIT   = 29;
  localparam int unsigned UBASR_PIH    = 30;
  localparam int unsigned UBASR_PIL    = 33;

  // Writable/clearable bits: 18-21, 26, 28-35.
  localparam logic [0:35] UBASR_WMASK = 36'o000000_741377;

  localparam logic [17:0] UBASR_ADDR = 18'o763100;

  typedef struct packed {
    logic tmo;
    logic bmd;
    logic bpe;
    logic nxd;
    logic pwrlow;
  } uba_err_t;

  function automatic logic dma_error(input uba_err_t e);
    return e.tmo | e.bmd | e.bpe | e.nxd;
  endfunction

  function automatic logic any_error(input uba_err_t e);
    return dma_error(e) | e.pwrlow;
  endfunction

endpackage

// File: rtl/uba_status_reg_init_timer.sv
// Loadable down-counter that holds ubaINIT high for INIT_CYCLES clocks after a load.
module uba_init_timer #(
  parameter int unsigned INIT_CYCLES = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic active
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= 8'(INIT_CYCLES);
    end else if (count != '0) begin
      count <= count - 8'd1;
    end
  end

  assign active = (count != '0);

endmodule

// File: rtl/uba_status_reg.sv
// UBA Status Register (UBASR): sticky error flags, PI level mapping, DXFR gate, init pulse.
// Optional macro UBA_ERRINT_EN: error flags also raise a request on the PIH level.
module uba_status_reg
  import uba_status_reg_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csrWRITE,
  input  logic [0:35] busDATAI,
  input  logic        setNXD,
  input  logic        setTMO,
  input  logic        setBMD,
  input  logic        setBPE,
  input  logic        setPWRLOW,
  input  logic        devINTH,
  input  logic        devINTL,
  output logic [0:35] regUBASR,
  output logic        ubaINIT,
  output logic        ubaDXFR,
  output logic [1:7]  piREQ
);

  uba_err_t    err;
  logic        dxfr;
  logic [2:0]  pih;
  logic [2:0]  pil;
  logic        inth;
  logic        intl;
  logic [0:35] wdata;
  logic        wr_init;
  uba_err_t    clr;
  logic        err_int;
  logic [1:7]  req;

  assign wdata   = busDATAI & UBASR_WMASK;
  assign wr_init = csrWRITE & wdata[UBASR_INIT];

  // An init write clears every flag regardless of the W1C bits in the same word.
  assign clr.tmo    = wr_init | (csrWRITE & wdata[UBASR_TMO]);
  assign clr.bmd    = wr_init | (csrWRITE & wdata[UBASR_BMD]);
  assign clr.bpe    = wr_init | (csrWRITE & wdata[UBASR_BPE]);
  assign clr.nxd    = wr_init | (csrWRITE & wdata[UBASR_NXD]);
  assign clr.pwrlow = wr_init | (csrWRITE & wdata[UBASR_PWRLOW]);

  uba_init_timer #(
    .INIT_CYCLES(INIT_CYCLES)
  ) u_init_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (wr_init),
    .active(ubaINIT)
  );

`ifdef UBA_ERRINT_EN
  assign err_int = any_error(err);
`else
  assign err_int = 1'b0;
`endif

  always_comb begin
    req = '0;
    for (int unsigned n = 1; n <= 7; n++) begin
      req[n] = (inth & (pih == 3'(n))) | (intl & (pil == 3'(n))) | (err_int & (pih == 3'(n)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err     <= '0;
      dxfr    <= 1'b0;
      pih     <= '0;
      pil     <= '0;
      inth    <= 1'b0;
      intl    <= 1'b0;
      piREQ   <= '0;
      ubaDXFR <= 1'b0;
    end else begin
      // Set has priority over any clear in the same cycle.
      err.tmo    <= setTMO    | (err.tmo    & ~clr.tmo);
      err.bmd    <= setBMD    | (err.bmd    & ~clr.bmd);
      err.bpe    <= setBPE    | (err.bpe    & ~clr.bpe);
      err.nxd    <= setNXD    | (err.nxd    & ~clr.nxd);
      err.pwrlow <= setPWRLOW | (err.pwrlow & ~clr.pwrlow);
      if (wr_init) begin
        dxfr <= 1'b0;
        pih  <= '0;
        pil  <= '0;
      end else if (csrWRITE) begin
        dxfr <= wdata[UBASR_DXFR];
        pih  <= wdata[UBASR_PIH +: 3];
        pil  <= wdata[UBASR_PIL +: 3];
      end
      inth    <= devINTH;
      intl    <= devINTL;
      piREQ   <= req;
      ubaDXFR <= dxfr & dma_error(err);
    end
  end

  always_comb begin
    regUBASR                   = '0;
    regUBASR[UBASR_TMO]        = err.tmo;
    regUBASR[UBASR_BMD]        = err.bmd;
    regUBASR[UBASR_BPE]        = err.bpe;
    regUBASR[UBASR_NXD]        = err.nxd;
    regUBASR[UBASR_INTH]       = inth;
    regUBASR[UBASR_INTL]       = intl;
    regUBASR[UBASR_PWRLOW]     = err.pwrlow;
    regUBASR[UBASR_DXFR]       = dxfr;
    regUBASR[UBASR_INIT]       = ubaINIT;
    regUBASR[UBASR_PIH +: 3]   = pih;
    regUBASR[UBASR_PIL +: 3]   = pil;
  end

endmodule
